y_row_writeback: RTL and testbench
==================================

Name: y_row_writeback

Overview:
Write-back engine that commits per-element Y-matrix updates into the row-organised Y memory. It accepts (row, col, complex value) update requests from the change/integration datapath. For each request it does a read-modify-write of the 256-bit memory word holding that element, then drives the memory write port (yMem_WEPin / yMem_WEAddress / ydataWrite). It sits between the integration datapath output and the Y memory.

Parameters:
ROWS, 32, number of Y-matrix rows stored
WORDS_PER_ROW, 8, 256-bit memory words per matrix row; 4 elements per word, so 32 columns max
ADDR_W, 8, memory address width; ROWS*WORDS_PER_ROW must be <= 2**ADDR_W

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
upd_valid  in  1  update request present
upd_ready  out  1  engine can accept a request
upd_row  in  16  target row index
upd_col  in  16  target column index
upd_real  in  24  signed real part
upd_img  in  24  signed imaginary part
upd_accum  in  1  1 = add to stored value, 0 = replace it
yMem_RDAddress  out  ADDR_W  memory read address
yMem_RDdata  in  256  memory read data, registered, 1-cycle latency
yMem_WEPin  out  1  memory write enable, one cycle per commit
yMem_WEAddress  out  ADDR_W  memory write address
ydataWrite  out  256  memory write data
wb_done  out  1  one-cycle pulse per completed commit
wb_err  out  1  sticky out-of-range flag
wb_count  out  16  number of completed commits, wraps

Behaviour:
- Reset (reset==0 at a clock edge) sets these values:
  - State IDLE, upd_ready=1.
  - yMem_WEPin=0, yMem_WEAddress=0, ydataWrite=0, yMem_RDAddress=0.
  - wb_done=0, wb_err=0, wb_count=0.
  - Reset mid-operation aborts the operation with no write.
- Address mapping:
  - addr = upd_row*WORDS_PER_ROW + upd_col[15:2].
  - lane = upd_col[1:0].
  - Lane k occupies bits [64k+47 : 64k] as {real[23:0], img[23:0]}, real in the upper half.
  - Bits [64k+63 : 64k+48] are written as 0.
- Handshake: a request is accepted when upd_valid & upd_ready at a clock edge. Request fields are latched at acceptance and need not be held afterwards. upd_ready is 1 only in IDLE.
- FSM: IDLE -> RD -> CAP -> MOD -> WR -> IDLE.
  - RD: drives yMem_RDAddress=addr.
  - CAP: registers yMem_RDdata.
  - MOD: computes the merged word into a register; the other three lanes are preserved bit-exactly.
  - WR: yMem_WEPin=1 with yMem_WEAddress=addr and ydataWrite=merged word, for exactly one cycle. wb_done pulses in the same cycle and wb_count increments.
- Latency: accept at edge T; write-enable high in cycle T+4. The next acceptance is possible at edge T+5, so throughput is one update per 5 cycles.
- upd_accum=1:
  - real and img are added independently as 24-bit two's-complement values.
  - Results saturate to 0x7FFFFF / 0x800000 on overflow.
- upd_accum=0: the lane becomes the new value directly.
- Out of range (upd_row>=ROWS or upd_col>=4*WORDS_PER_ROW):
  - The request is still accepted; wb_err is set (sticky until reset).
  - No read and no write occur, and wb_done and wb_count are unchanged.
  - The FSM returns to IDLE on the next cycle.
- Back-to-back updates to the same word need no forwarding, because each write completes before the next read is issued.
- yMem_WEPin is never high outside the WR state.

Decomposition:
- Shared package y_wb_pkg:
  - FSM state enum.
  - Lane width 64 and element width 48.
  - Field widths 24.
  - Saturation constants 24'h7FFFFF and 24'h800000.
- One sub-module, y_cplx_sat_add: a combinational 24-bit signed saturating adder, instantiated twice (real and imaginary).

Test Plan:
- Replace: memory preloaded with zeros; request row=0, col=16, real=24'h4ebd90, img=24'h5c2e27, accum=0 -> WE high 4 cycles after accept, address 4, ydataWrite[47:0]=48'h4ebd905c2e27, all other bits 0, wb_count=1.
- Accumulate: word 4 lane 1 holds {24'h000010, 24'hFFFFF0}; request row=0, col=17, real=24'h000005, img=24'h000020, accum=1 -> lane 1 becomes {24'h000015, 24'h000010}; lanes 0, 2, 3 are unchanged.
- Saturation: stored real 24'h7FFFF0 plus 24'h000020 -> real 24'h7FFFFF. Stored img 24'h800010 plus 24'hFFFF00 -> img 24'h800000.
- Range error: row=32, col=0 -> wb_err=1, no yMem_WEPin pulse, upd_ready back to 1 two cycles after accept, wb_count unchanged.
- Back-to-back throughput: upd_valid held high with 3 accumulate requests of +1 to the same element -> accepts at edges T, T+5, T+10; final stored value is the initial value +3.
- Reset mid-op: drive reset=0 in the cycle after accept -> no write occurs, all outputs at reset values, upd_ready=1 once reset is released.

Source files
------------

// File: rtl/y_wb_pkg.sv
// y_wb_pkg: shared types and constants for the Y-matrix row write-back engine.
//   wb_state_e        : write-back FSM states (IDLE -> RD -> CAP -> MOD -> WR)
//   LANE_W / ELEM_W   : 64-bit lane per element, 48 bits of payload {real, img}
//   FIELD_W           : width of each signed real / imaginary field
//   SAT_MAX / SAT_MIN : saturation limits for 24-bit two's-complement sums
package y_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_MOD,
    ST_WR
  } wb_state_e;

  localparam int unsigned LANE_W  = 64;
  localparam int unsigned ELEM_W  = 48;
  localparam int unsigned FIELD_W = 24;

  localparam logic [FIELD_W-1:0] SAT_MAX = 24'h7FFFFF;
  localparam logic [FIELD_W-1:0] SAT_MIN = 24'h800000;

endpackage

// File: rtl/y_row_writeback_if.sv
// y_row_writeback_if: update-request channel into the Y-matrix write-back engine.
//   upd_valid / upd_ready : request handshake (accepted when both high at a clock edge)
//   upd_row / upd_col     : target element coordinates
//   upd_real / upd_img    : signed 24-bit complex value
//   upd_accum             : 1 = add to stored value, 0 = replace it
// master = request producer (integration datapath), slave = write-back engine.
interface y_row_writeback_if;
  import y_wb_pkg::*;

  logic               upd_valid;
  logic               upd_ready;
  logic [15:0]        upd_row;
  logic [15:0]        upd_col;
  logic [FIELD_W-1:0] upd_real;
  logic [FIELD_W-1:0] upd_img;
  logic               upd_accum;

  modport master (
    output upd_valid, upd_row, upd_col, upd_real, upd_img, upd_accum,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_row, upd_col, upd_real, upd_img, upd_accum,
    output upd_ready
  );

endinterface

// File: rtl/y_cplx_sat_add.sv
// y_cplx_sat_add: combinational 24-bit signed adder with saturation.
//   a_i, b_i : two's-complement operands
//   sum_o    : a_i + b_i clamped to [SAT_MIN, SAT_MAX]
module y_cplx_sat_add
  import y_wb_pkg::*;
(
  input  logic [FIELD_W-1:0] a_i,
  input  logic [FIELD_W-1:0] b_i,
  output logic [FIELD_W-1:0] sum_o
);

  logic [FIELD_W:0] wide;

  always_comb begin
    wide = {a_i[FIELD_W-1], a_i} + {b_i[FIELD_W-1], b_i};
    // Top two bits of the sign-extended sum disagree only on overflow;
    // the extra bit holds the true sign and picks the limit.
    if (wide[FIELD_W] != wide[FIELD_W-1]) begin
      sum_o = wide[FIELD_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = wide[FIELD_W-1:0];
    end
  end

endmodule

// File: rtl/y_row_writeback.sv
// y_row_writeback: read-modify-write engine committing per-element Y-matrix
// updates into the row-organised 256-bit Y memory (4 elements per word).
//   clock, reset         : system clock, synchronous active-low reset
//   upd (slave)          : update request channel
//   yMem_RDAddress       : memory read address (data returns one cycle later)
//   yMem_RDdata          : memory read data
//   yMem_WEPin           : write enable, one cycle per committed update
//   yMem_WEAddress       : write address
//   ydataWrite           : merged write word
//   wb_done              : one-cycle pulse per commit
//   wb_err               : sticky out-of-range request flag
//   wb_count             : committed update count (wraps)
module y_row_writeback
  import y_wb_pkg::*;
#(
  parameter int unsigned ROWS          = 32,
  parameter int unsigned WORDS_PER_ROW = 8,
  parameter int unsigned ADDR_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  y_row_writeback_if.slave  upd,
  output logic [ADDR_W-1:0] yMem_RDAddress,
  input  logic [255:0]      yMem_RDdata,
  output logic              yMem_WEPin,
  output logic [ADDR_W-1:0] yMem_WEAddress,
  output logic [255:0]      ydataWrite,
  output logic              wb_done,
  output logic              wb_err,
  output logic [15:0]       wb_count
);

  wb_state_e          state_q, state_d;

  logic               accept;
  logic               in_range;
  logic [31:0]        addr_full;
  logic [ADDR_W-1:0]  req_addr;

  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [1:0]         lane_q;
  logic [FIELD_W-1:0] real_q;
  logic [FIELD_W-1:0] img_q;
  logic               accum_q;
  logic               ok_q;
  logic               err_q;
  logic [15:0]        count_q;
  logic [255:0]       cap_q;
  logic [255:0]       merged_q, merged_d;

  logic [LANE_W-1:0]  old_lane;
  logic [FIELD_W-1:0] sum_re, sum_im;
  logic [FIELD_W-1:0] new_re, new_im;

  // Request decode: word address and range check on the live request fields.
  always_comb begin
    addr_full = 32'(upd.upd_row) * 32'(WORDS_PER_ROW) + 32'(upd.upd_col[15:2]);
    req_addr  = addr_full[ADDR_W-1:0];
    in_range  = (32'(upd.upd_row) < ROWS) && (32'(upd.upd_col) < 32'(4 * WORDS_PER_ROW));
  end

  assign upd.upd_ready = (state_q == ST_IDLE);
  assign accept        = upd.upd_valid && upd.upd_ready;

  always_comb begin
    state_d    = state_q;
    yMem_WEPin = 1'b0;
    wb_done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (upd.upd_valid) state_d = ST_RD;
      // Out-of-range requests end here: the read address was never updated
      // and nothing downstream is touched.
      ST_RD:   state_d = ok_q ? ST_CAP : ST_IDLE;
      ST_CAP:  state_d = ST_MOD;
      ST_MOD:  state_d = ST_WR;
      ST_WR: begin
        yMem_WEPin = 1'b1;
        wb_done    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lane merge: only the addressed lane changes; its top 16 bits are cleared.
  always_comb begin
    old_lane = cap_q[{lane_q, 6'b0} +: LANE_W];
    new_re   = accum_q ? sum_re : real_q;
    new_im   = accum_q ? sum_im : img_q;
    merged_d = cap_q;
    merged_d[{lane_q, 6'b0} +: LANE_W] = {{(LANE_W-ELEM_W){1'b0}}, new_re, new_im};
  end

  y_cplx_sat_add u_add_re (
    .a_i   (old_lane[ELEM_W-1:FIELD_W]),
    .b_i   (real_q),
    .sum_o (sum_re)
  );

  y_cplx_sat_add u_add_im (
    .a_i   (old_lane[FIELD_W-1:0]),
    .b_i   (img_q),
    .sum_o (sum_im)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      lane_q    <= '0;
      real_q    <= '0;
      img_q     <= '0;
      accum_q   <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      cap_q     <= '0;
      merged_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        lane_q  <= upd.upd_col[1:0];
        real_q  <= upd.upd_real;
        img_q   <= upd.upd_img;
        accum_q <= upd.upd_accum;
        ok_q    <= in_range;
        if (in_range) begin
          rd_addr_q <= req_addr;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state_q == ST_CAP) cap_q    <= yMem_RDdata;
      if (state_q == ST_MOD) merged_q <= merged_d;
      if (state_q == ST_WR)  count_q  <= count_q + 16'd1;
    end
  end

  assign yMem_RDAddress = rd_addr_q;
  assign yMem_WEAddress = addr_q;
  assign ydataWrite     = merged_q;
  assign wb_err         = err_q;
  assign wb_count       = count_q;

endmodule

// File: tb/tb_y_row_writeback.sv
// tb_y_row_writeback: self-checking bench for y_row_writeback with a bench-side
// Y memory and an element-level reference model (integer add + clamp).
module tb_y_row_writeback;
  import y_wb_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   rd_addr, we_addr;
  logic [255:0] rd_data, wdata;
  logic         we, done, err;
  logic [15:0]  count;

  always #5 clock = ~clock;

  y_row_writeback_if upd_if ();

  y_row_writeback #(
    .ROWS          (32),
    .WORDS_PER_ROW (8),
    .ADDR_W        (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .upd            (upd_if),
    .yMem_RDAddress (rd_addr),
    .yMem_RDdata    (rd_data),
    .yMem_WEPin     (we),
    .yMem_WEAddress (we_addr),
    .ydataWrite     (wdata),
    .wb_done        (done),
    .wb_err         (err),
    .wb_count       (count)
  );

  // Bench memory: registered read, write port from DUT or from bench preload.
  logic [255:0] mem [256];
  logic         tb_wr = 1'b0;
  logic [7:0]   tb_addr = '0;
  logic [255:0] tb_data = '0;

  always @(posedge clock) begin
    rd_data <= mem[rd_addr];
    if (tb_wr) mem[tb_addr] <= tb_data;
    else if (we) mem[we_addr] <= wdata;
  end

  logic [255:0] ref_mem [256];
  int           ref_count;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int clamp24(input int v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] w, input int lane,
                                         input logic [23:0] re, input logic [23:0] im,
                                         input logic acc);
    logic [255:0]       o;
    logic [63:0]        old;
    logic signed [23:0] ore, oim, nre, nim;
    int                 r, i;
    o   = w;
    old = w[lane*64 +: 64];
    ore = old[47:24];
    oim = old[23:0];
    nre = re;
    nim = im;
    if (acc) begin
      r = clamp24(int'(ore) + int'(nre));
      i = clamp24(int'(oim) + int'(nim));
    end else begin
      r = int'(nre);
      i = int'(nim);
    end
    o[lane*64 +: 64] = {16'h0, r[23:0], i[23:0]};
    return o;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic preload(input int a, input logic [255:0] d);
    @(negedge clock);
    tb_wr   = 1'b1;
    tb_addr = 8'(a);
    tb_data = d;
    @(negedge clock);
    tb_wr = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic drive_junk();
    upd_if.upd_row   = 16'($urandom);
    upd_if.upd_col   = 16'($urandom);
    upd_if.upd_real  = 24'($urandom);
    upd_if.upd_img   = 24'($urandom);
    upd_if.upd_accum = 1'($urandom);
  endtask

  // One request: checks write timing/address/data, ready return and counters.
  task automatic send(input logic [15:0] row, input logic [15:0] col,
                      input logic [23:0] re, input logic [23:0] im, input logic acc);
    logic         oor;
    int           a, lane, we_k, n_we, rdy_ok;
    logic [255:0] exp_w;
    logic [15:0]  cnt0;
    oor  = (row >= 16'd32) || (col >= 16'd32);
    a    = int'(row) * 8 + int'(col[15:2]);
    lane = int'(col[1:0]);
    @(negedge clock);
    upd_if.upd_row   = row;
    upd_if.upd_col   = col;
    upd_if.upd_real  = re;
    upd_if.upd_img   = im;
    upd_if.upd_accum = acc;
    upd_if.upd_valid = 1'b1;
    rdy_ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (upd_if.upd_ready) begin rdy_ok = 1; break; end
      @(negedge clock);
    end
    if (rdy_ok == 0) begin
      check("ready_timeout", 0, 1);
      upd_if.upd_valid = 1'b0;
      return;
    end
    cnt0  = count;
    exp_w = oor ? '0 : model(ref_mem[a], lane, re, im, acc);
    @(posedge clock);
    @(negedge clock);
    upd_if.upd_valid = 1'b0;
    drive_junk();
    we_k = 0;
    n_we = 0;
    for (int k = 1; k <= 7; k++) begin
      if (we) begin
        n_we++;
        if (we_k == 0) begin
          we_k = k;
          check("we_addr", we_addr, a);
          check("we_data", wdata, exp_w);
          check("done_with_we", done, 1);
        end
      end
      if (oor && k == 2) check("oor_ready_back", upd_if.upd_ready, 1);
      if (!oor && k == 5) check("ready_after_wr", upd_if.upd_ready, 1);
      @(negedge clock);
    end
    check("we_pulses", n_we, oor ? 0 : 1);
    if (oor) begin
      check("oor_err", err, 1);
      check("oor_count", count, cnt0);
    end else begin
      check("we_latency", we_k, 4);
      ref_mem[a] = exp_w;
      ref_count++;
      check("count", count, 16'(ref_count));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [255:0] w;
    int           acc_idx [3];
    int           n, n_we, bad;

    reset            = 1'b0;
    upd_if.upd_valid = 1'b0;
    drive_junk();
    ref_count = 0;

    for (int a = 0; a < 256; a++) preload(a, rand256());

    // Reset values
    @(negedge clock);
    check("rst_ready", upd_if.upd_ready, 1);
    check("rst_we", we, 0);
    check("rst_we_addr", we_addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    reset = 1'b1;

    // Replace into zeroed word
    preload(4, '0);
    send(16'd0, 16'd16, 24'h4ebd90, 24'h5c2e27, 1'b0);
    check("replace_word", mem[4], {208'h0, 48'h4ebd905c2e27});

    // Accumulate, other lanes preserved
    w = rand256();
    w[127:64] = {16'h1234, 24'h000010, 24'hFFFFF0};
    preload(4, w);
    send(16'd0, 16'd17, 24'h000005, 24'h000020, 1'b1);
    check("acc_lane1", mem[4][127:64], {16'h0, 24'h000015, 24'h000010});
    check("acc_lane0", mem[4][63:0], w[63:0]);
    check("acc_lane23", mem[4][255:128], w[255:128]);

    // Saturation both directions
    w = rand256();
    w[191:128] = {16'h0, 24'h7FFFF0, 24'h800010};
    preload(12, w);
    send(16'd1, 16'd18, 24'h000020, 24'hFFFF00, 1'b1);
    check("sat_lane2", mem[12][191:128], {16'h0, 24'h7FFFFF, 24'h800000});

    // Range error
    check("err_before", err, 0);
    send(16'd32, 16'd0, 24'h000001, 24'h000001, 1'b0);

    // Back-to-back accumulates to one element
    w = rand256();
    w[127:64] = {16'hBEEF, 24'h000100, 24'hFFFFFE};
    preload(17, w);
    @(negedge clock);
    upd_if.upd_row   = 16'd2;
    upd_if.upd_col   = 16'd5;
    upd_if.upd_real  = 24'h000001;
    upd_if.upd_img   = 24'h000001;
    upd_if.upd_accum = 1'b1;
    upd_if.upd_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (upd_if.upd_ready) begin
        acc_idx[n] = i;
        n++;
      end
      @(negedge clock);
      if (n == 3) begin
        upd_if.upd_valid = 1'b0;
        break;
      end
    end
    check("b2b_accepts", n, 3);
    if (n == 3) begin
      check("b2b_gap1", acc_idx[1] - acc_idx[0], 5);
      check("b2b_gap2", acc_idx[2] - acc_idx[1], 5);
    end
    repeat (8) @(negedge clock);
    for (int k = 0; k < 3; k++) ref_mem[17] = model(ref_mem[17], 1, 24'h000001, 24'h000001, 1'b1);
    ref_count += 3;
    check("b2b_lane", mem[17][127:64], {16'h0, 24'h000103, 24'h000001});
    check("b2b_word", mem[17], ref_mem[17]);
    check("b2b_count", count, 16'(ref_count));

    // Reset in the cycle after accept
    @(negedge clock);
    upd_if.upd_row   = 16'd3;
    upd_if.upd_col   = 16'd9;
    upd_if.upd_real  = 24'h123456;
    upd_if.upd_img   = 24'h654321;
    upd_if.upd_accum = 1'b0;
    upd_if.upd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    upd_if.upd_valid = 1'b0;
    reset = 1'b0;
    n_we = 0;
    @(negedge clock);
    check("mid_rst_we_addr", we_addr, 0);
    check("mid_rst_wdata", wdata, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_count", count, 0);
    reset = 1'b1;
    ref_count = 0;
    for (int k = 0; k < 6; k++) begin
      if (we) n_we++;
      @(negedge clock);
    end
    check("mid_rst_no_we", n_we, 0);
    check("mid_rst_ready", upd_if.upd_ready, 1);

    // Randomized requests, including out-of-range and saturating cases
    for (int t = 0; t < 24; t++) begin
      send(16'($urandom_range(0, 34)), 16'($urandom_range(0, 35)),
           24'($urandom), 24'($urandom), 1'($urandom));
    end

    bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
    check("mem_final_words", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
